// File: rtl/cpu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer_pkg
//  Description : Shared RV32I control constants: FSM state encodings, major
//                opcode values (ir[6:2]), branch funct3 codes and opcode
//                classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd7
   } state_t;

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // True for the nine RV32I major opcodes this core executes
   function automatic logic opc_legal(input logic [4:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
         OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: opc_legal = 1'b1;
         default:                                opc_legal = 1'b0;
      endcase
   endfunction

   // True for opcodes that write rd in WB (everything but BRANCH/STORE)
   function automatic logic opc_writes_rd(input logic [4:0] opc);
      opc_writes_rd = opc_legal(opc) && (opc != OPC_BRANCH) && (opc != OPC_STORE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer_if
//  Description : Memory handshake, decode and datapath signals between the
//                sequencer (master) and its environment (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_sequencer_if;
   logic [31:0] I_imem_data;
   logic        I_imem_ack;
   logic        O_imem_req;
   logic [31:0] O_pc;
   logic [31:0] O_ir;
   logic [31:0] I_pcincr;
   logic        I_breq;
   logic        I_brlt;
   logic        O_brun;
   logic [31:0] I_alu_result;
   logic        O_dmem_req;
   logic        O_dmem_we;
   logic        I_dmem_ack;
   logic        O_rf_we;
   logic [2:0]  O_state;
   logic        O_fault;

   modport master (
      input  I_imem_data, I_imem_ack, I_pcincr, I_breq, I_brlt,
             I_alu_result, I_dmem_ack,
      output O_imem_req, O_pc, O_ir, O_brun, O_dmem_req, O_dmem_we,
             O_rf_we, O_state, O_fault
   );

   modport slave (
      output I_imem_data, I_imem_ack, I_pcincr, I_breq, I_brlt,
             I_alu_result, I_dmem_ack,
      input  O_imem_req, O_pc, O_ir, O_brun, O_dmem_req, O_dmem_we,
             O_rf_we, O_state, O_fault
   );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer_branch_resolve
//  Description : Combinational branch-taken decision from funct3 and the
//                comparator flags. funct3 010/011 are never taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer_branch_resolve
   import cpu_sequencer_pkg::*;
(
   input  wire logic [2:0] funct3_i,
   input  wire logic       breq_i,
   input  wire logic       brlt_i,
   output logic            taken_o
);

   // Map funct3 onto the equal / less-than flags
   always_comb begin
      taken_o = 1'b0;
      case (funct3_i)
         F3_BEQ:           taken_o = breq_i;
         F3_BNE:           taken_o = !breq_i;
         F3_BLT, F3_BLTU:  taken_o = brlt_i;
         F3_BGE, F3_BGEU:  taken_o = !brlt_i;
         default:          taken_o = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Multi-cycle RV32I control sequencer. Owns PC and IR, walks
//                each instruction through FETCH/DECODE/EXEC/MEM/WB, and
//                latches a sticky fault on illegal opcodes or memory timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
)(
   input  wire logic       I_clk,
   input  wire logic       I_rstn,
   cpu_sequencer_if.master bus
);

   // Last wait cycle in which an ack is still accepted
   localparam logic [7:0] c_wait_limit = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic        imem_req_q;
   logic        dmem_req_q;
   logic        dmem_we_q;
   logic        rf_we_q;
   logic        fault_q;
   logic        taken_q;
   logic [7:0]  wcnt_q;

   logic [4:0]  w_opc;
   logic        w_taken;
   logic        w_wait_expired;
   logic [31:0] w_pc_d;

   assign w_opc          = ir_q[6:2];
   assign w_wait_expired = (wcnt_q == c_wait_limit);

   cpu_sequencer_branch_resolve u_branch_resolve (
      .funct3_i (ir_q[14:12]),
      .breq_i   (bus.I_breq),
      .brlt_i   (bus.I_brlt),
      .taken_o  (w_taken)
   );

   // Next PC applied in WB: jump/taken-branch target, JALR target, or PC+incr
   always_comb begin
      w_pc_d = pc_q + bus.I_pcincr;
      if (w_opc == OPC_JAL || (w_opc == OPC_BRANCH && taken_q))
         w_pc_d = bus.I_alu_result;
      else if (w_opc == OPC_JALR)
         w_pc_d = {bus.I_alu_result[31:1], 1'b0};
   end

   // Sequencer FSM with registered handshake outputs
   always_ff @(posedge I_clk or negedge I_rstn) begin
      if (!I_rstn) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         ir_q       <= 32'h0;
         imem_req_q <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         rf_we_q    <= 1'b0;
         fault_q    <= 1'b0;
         taken_q    <= 1'b0;
         wcnt_q     <= 8'h0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (!imem_req_q) begin
                  // first cycle after reset release: raise the request
                  imem_req_q <= 1'b1;
                  wcnt_q     <= 8'h0;
               end else if (bus.I_imem_ack) begin
                  ir_q       <= bus.I_imem_data;
                  imem_req_q <= 1'b0;
                  state_q    <= ST_DECODE;
               end else if (w_wait_expired) begin
                  imem_req_q <= 1'b0;
                  fault_q    <= 1'b1;
                  state_q    <= ST_HALT;
               end else begin
                  wcnt_q <= wcnt_q + 8'd1;
               end
            end
            ST_DECODE: begin
               if (ir_q == 32'h0 || !opc_legal(w_opc)) begin
                  fault_q <= 1'b1;
                  state_q <= ST_HALT;
               end else begin
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               taken_q <= w_taken;
               if (w_opc == OPC_LOAD || w_opc == OPC_STORE) begin
                  dmem_req_q <= 1'b1;
                  dmem_we_q  <= (w_opc == OPC_STORE);
                  wcnt_q     <= 8'h0;
                  state_q    <= ST_MEM;
               end else begin
                  rf_we_q <= opc_writes_rd(w_opc);
                  state_q <= ST_WB;
               end
            end
            ST_MEM: begin
               if (bus.I_dmem_ack) begin
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  rf_we_q    <= (w_opc == OPC_LOAD);
                  state_q    <= ST_WB;
               end else if (w_wait_expired) begin
                  dmem_req_q <= 1'b0;
                  dmem_we_q  <= 1'b0;
                  fault_q    <= 1'b1;
                  state_q    <= ST_HALT;
               end else begin
                  wcnt_q <= wcnt_q + 8'd1;
               end
            end
            ST_WB: begin
               rf_we_q    <= 1'b0;
               pc_q       <= w_pc_d;
               imem_req_q <= 1'b1;
               wcnt_q     <= 8'h0;
               state_q    <= ST_FETCH;
            end
            ST_HALT: begin
               // frozen until reset
               state_q <= ST_HALT;
            end
            default: begin
               imem_req_q <= 1'b0;
               dmem_req_q <= 1'b0;
               dmem_we_q  <= 1'b0;
               rf_we_q    <= 1'b0;
               fault_q    <= 1'b1;
               state_q    <= ST_HALT;
            end
         endcase
      end
   end

   assign bus.O_imem_req = imem_req_q;
   assign bus.O_pc       = pc_q;
   assign bus.O_ir       = ir_q;
   assign bus.O_brun     = ir_q[13];
   assign bus.O_dmem_req = dmem_req_q;
   assign bus.O_dmem_we  = dmem_we_q;
   assign bus.O_rf_we    = rf_we_q;
   assign bus.O_state    = state_q;
   assign bus.O_fault    = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Directed self-checking bench for cpu_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

   localparam logic [31:0] INS_ADDI = 32'h0010_0093;
   localparam logic [31:0] INS_LW   = 32'h0000_A103;
   localparam logic [31:0] INS_SW   = 32'h0020_A023;
   localparam logic [31:0] INS_BEQ  = 32'h0020_8063;
   localparam logic [31:0] INS_BGEU = 32'h0020_F063;
   localparam logic [31:0] INS_JAL  = 32'h0000_00EF;
   localparam logic [31:0] INS_JALR = 32'h0000_80E7;
   localparam logic [31:0] INS_BAD  = 32'h0000_007F;

   logic clk;
   logic rstn;
   int   n_vec;
   int   n_err;

   cpu_sequencer_if bus();

   cpu_sequencer #(
      .RESET_PC (32'h0000_0000),
      .TIMEOUT  (16)
   ) dut (
      .I_clk  (clk),
      .I_rstn (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Fetch with same-cycle ack, then step a non-memory instruction to next FETCH
   task automatic run_insn(input string tag, input logic [31:0] insn,
                           input logic exp_we, input logic [31:0] exp_pc);
      chk({tag, "_fetch_state"}, 32'(bus.O_state), 32'd0);
      chk({tag, "_fetch_req"},   32'(bus.O_imem_req), 32'd1);
      bus.I_imem_data = insn;
      bus.I_imem_ack  = 1'b1;
      tick();
      bus.I_imem_ack  = 1'b0;
      chk({tag, "_dec_state"}, 32'(bus.O_state), 32'd1);
      chk({tag, "_ir"},        bus.O_ir, insn);
      tick();
      chk({tag, "_exec_state"}, 32'(bus.O_state), 32'd2);
      tick();
      chk({tag, "_wb_state"}, 32'(bus.O_state), 32'd4);
      chk({tag, "_wb_rfwe"},  32'(bus.O_rf_we), 32'(exp_we));
      tick();
      chk({tag, "_next_state"}, 32'(bus.O_state), 32'd0);
      chk({tag, "_next_rfwe"},  32'(bus.O_rf_we), 32'd0);
      chk({tag, "_pc"},         bus.O_pc, exp_pc);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #12;
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rstn  = 1'b0;
      bus.I_imem_data  = 32'h0;
      bus.I_imem_ack   = 1'b0;
      bus.I_pcincr     = 32'd4;
      bus.I_breq       = 1'b0;
      bus.I_brlt       = 1'b0;
      bus.I_alu_result = 32'h0;
      bus.I_dmem_ack   = 1'b0;
      #13;

      // ---- reset state ----
      chk("rst_state", 32'(bus.O_state), 32'd0);
      chk("rst_pc",    bus.O_pc, 32'h0);
      chk("rst_ir",    bus.O_ir, 32'h0);
      chk("rst_fault", 32'(bus.O_fault), 32'd0);
      chk("rst_ireq",  32'(bus.O_imem_req), 32'd0);
      chk("rst_dreq",  32'(bus.O_dmem_req), 32'd0);
      chk("rst_rfwe",  32'(bus.O_rf_we), 32'd0);
      rstn = 1'b1;
      tick();

      // ---- ADDI, 4 cycles, pc 0->4 ----
      run_insn("addi", INS_ADDI, 1'b1, 32'h4);

      // ---- LW, dmem ack 3 cycles after req: 8 cycles total ----
      bus.I_imem_data = INS_LW;
      bus.I_imem_ack  = 1'b1;
      tick();
      bus.I_imem_ack  = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("lw_mem_state", 32'(bus.O_state), 32'd3);
         chk("lw_dreq",      32'(bus.O_dmem_req), 32'd1);
         chk("lw_dwe",       32'(bus.O_dmem_we), 32'd0);
         if (i == 3) bus.I_dmem_ack = 1'b1;
         tick();
      end
      bus.I_dmem_ack = 1'b0;
      chk("lw_wb_state", 32'(bus.O_state), 32'd4);
      chk("lw_wb_rfwe",  32'(bus.O_rf_we), 32'd1);
      chk("lw_wb_dreq",  32'(bus.O_dmem_req), 32'd0);
      tick();
      chk("lw_pc", bus.O_pc, 32'h8);
      chk("lw_rfwe_off", 32'(bus.O_rf_we), 32'd0);

      // ---- branches ----
      bus.I_alu_result = 32'h40;
      bus.I_breq = 1'b1;
      run_insn("beq_t", INS_BEQ, 1'b0, 32'h40);
      bus.I_breq = 1'b0;
      run_insn("beq_nt", INS_BEQ, 1'b0, 32'h44);
      bus.I_brlt = 1'b1;
      run_insn("bgeu_nt", INS_BGEU, 1'b0, 32'h48);
      chk("bgeu_brun", 32'(bus.O_brun), 32'd1);
      bus.I_brlt = 1'b0;

      // ---- JALR clears bit 0; JAL to top of space then PC wraps ----
      bus.I_alu_result = 32'h0000_0101;
      run_insn("jalr", INS_JALR, 1'b1, 32'h100);
      bus.I_alu_result = 32'hFFFF_FFFC;
      run_insn("jal", INS_JAL, 1'b1, 32'hFFFF_FFFC);
      run_insn("wrap", INS_ADDI, 1'b1, 32'h0);

      // ---- async reset during MEM of a store ----
      bus.I_imem_data = INS_SW;
      bus.I_imem_ack  = 1'b1;
      tick();
      bus.I_imem_ack  = 1'b0;
      tick();
      tick();
      chk("sw_dreq", 32'(bus.O_dmem_req), 32'd1);
      chk("sw_dwe",  32'(bus.O_dmem_we), 32'd1);
      tick();
      rstn = 1'b0;
      #1;
      chk("sw_rst_dreq",  32'(bus.O_dmem_req), 32'd0);
      chk("sw_rst_dwe",   32'(bus.O_dmem_we), 32'd0);
      chk("sw_rst_pc",    bus.O_pc, 32'h0);
      chk("sw_rst_fault", 32'(bus.O_fault), 32'd0);
      chk("sw_rst_state", 32'(bus.O_state), 32'd0);
      chk("sw_rst_rfwe",  32'(bus.O_rf_we), 32'd0);
      #10;
      rstn = 1'b1;
      chk("sw_rel_ireq0", 32'(bus.O_imem_req), 32'd0);
      tick();
      chk("sw_rel_ireq1", 32'(bus.O_imem_req), 32'd1);

      // ---- ack in the last accepted wait cycle: no fault ----
      for (int i = 0; i < 15; i++) tick();
      chk("to_late_state", 32'(bus.O_state), 32'd0);
      chk("to_late_fault", 32'(bus.O_fault), 32'd0);
      bus.I_imem_data = INS_ADDI;
      bus.I_imem_ack  = 1'b1;
      tick();
      bus.I_imem_ack  = 1'b0;
      chk("to_late_dec", 32'(bus.O_state), 32'd1);
      chk("to_late_nofault", 32'(bus.O_fault), 32'd0);
      tick();
      tick();
      tick();
      chk("to_late_pc", bus.O_pc, 32'h4);

      // ---- imem never acks: fault exactly 16 cycles after req ----
      for (int i = 0; i < 16; i++) begin
         chk("to_wait_fault", 32'(bus.O_fault), 32'd0);
         tick();
      end
      chk("to_fault", 32'(bus.O_fault), 32'd1);
      chk("to_state", 32'(bus.O_state), 32'd7);
      chk("to_ireq",  32'(bus.O_imem_req), 32'd0);

      // ---- all-zero instruction ----
      do_reset();
      bus.I_imem_data = 32'h0;
      bus.I_imem_ack  = 1'b1;
      tick();
      bus.I_imem_ack  = 1'b0;
      chk("zero_dec_fault", 32'(bus.O_fault), 32'd0);
      tick();
      chk("zero_fault", 32'(bus.O_fault), 32'd1);
      chk("zero_state", 32'(bus.O_state), 32'd7);

      // ---- illegal opcode, then HALT is frozen and ignores acks ----
      do_reset();
      bus.I_imem_data = INS_BAD;
      bus.I_imem_ack  = 1'b1;
      tick();
      bus.I_imem_ack  = 1'b0;
      tick();
      chk("bad_fault", 32'(bus.O_fault), 32'd1);
      chk("bad_state", 32'(bus.O_state), 32'd7);
      bus.I_imem_data = INS_ADDI;
      for (int i = 0; i < 20; i++) begin
         bus.I_imem_ack = (i == 5);
         bus.I_dmem_ack = (i == 6);
         tick();
         chk("halt_ireq", 32'(bus.O_imem_req), 32'd0);
      end
      bus.I_imem_ack = 1'b0;
      bus.I_dmem_ack = 1'b0;
      chk("halt_ir",    bus.O_ir, INS_BAD);
      chk("halt_pc",    bus.O_pc, 32'h0);
      chk("halt_state", 32'(bus.O_state), 32'd7);
      chk("halt_dreq",  32'(bus.O_dmem_req), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the RV32I core. It owns the PC and the instruction register, and handshakes with instruction and data memory. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, driving the decode stage's I_data and consuming decode's O_pcincr and the branch comparator flags (breq/brlt). It also flags illegal or all-zero instructions and memory timeouts as a sticky fault.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
TIMEOUT, 16, max wait cycles for a memory ack before fault (range 1..255)

Ports:
I_clk  in  1  core clock, rising edge
I_rstn  in  1  asynchronous active-low reset
I_imem_data  in  32  instruction word from instruction memory
I_imem_ack  in  1  instruction memory data valid, single-cycle pulse
O_imem_req  out  1  instruction fetch request, held until ack
O_pc  out  32  current PC, also the fetch address
O_ir  out  32  latched instruction, feeds decode I_data
I_pcincr  in  32  PC increment from decode (4)
I_breq  in  1  comparator rs1==rs2
I_brlt  in  1  comparator rs1<rs2 (signedness per O_brun)
O_brun  out  1  comparator unsigned mode = O_ir[13]
I_alu_result  in  32  ALU output: branch/jump target or memory address
O_dmem_req  out  1  data memory request, held until ack
O_dmem_we  out  1  1 = store, 0 = load; valid while O_dmem_req
I_dmem_ack  in  1  data memory done, single-cycle pulse
O_rf_we  out  1  register-file write enable, one cycle in WB
O_state  out  3  current state encoding, for debug
O_fault  out  1  sticky fault flag

Behaviour:
- Reset (async assert, sync release):
  - state=FETCH; O_pc=RESET_PC; O_ir=0; O_fault=0.
  - All req/we outputs are 0; wait counter=0.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- FETCH:
  - O_imem_req=1 while in this state.
  - On I_imem_ack: O_ir<=I_imem_data, go to DECODE. A same-cycle ack gives 1 cycle in FETCH.
- DECODE (1 cycle):
  - Classify opcode O_ir[6:2].
  - Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - O_ir==0 or any other opcode: O_fault<=1, go to HALT.
- EXEC (1 cycle):
  - LOAD/STORE go to MEM. All others go to WB.
  - Branch-taken is computed here from O_ir[14:12]:
    - BEQ: breq. BNE: !breq.
    - BLT/BLTU: brlt. BGE/BGEU: !brlt.
    - funct3 010/011 counts as not taken.
  - The taken result is registered for WB.
- MEM:
  - O_dmem_req=1; O_dmem_we=1 for STORE.
  - On I_dmem_ack, go to WB.
- WB (1 cycle):
  - O_rf_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP. It is 0 for BRANCH and STORE.
  - PC update:
    - JAL, or BRANCH taken: O_pc<=I_alu_result.
    - JALR: O_pc<=I_alu_result with bit0 cleared.
    - Otherwise: O_pc<=O_pc+I_pcincr, mod 2^32 (wraps at 32'hFFFFFFFC+4 -> 0).
  - Then go to FETCH.
- Latency, ack in the first cycle of each wait:
  - ALU/branch/jump instruction: 4 cycles.
  - Load/store: 5 cycles.
  - Each extra wait cycle adds 1.
- Timeout:
  - An 8-bit counter clears on entering FETCH or MEM and increments each cycle without ack.
  - If it reaches TIMEOUT with no ack: O_fault<=1, go to HALT, drop the request.
  - An ack in the same cycle the limit is reached wins.
- HALT:
  - All req/we outputs are 0; O_pc and O_ir are frozen.
  - Only I_rstn exits HALT.
- Ack arriving when its req is 0 is ignored.
- Reset asserted mid-MEM or mid-FETCH: outputs return to reset values immediately, with no write. O_rf_we=0.

Decomposition:
- Shared package/header `control.vh` gains:
  - Opcode constants OPC_LUI..OPC_OP (5-bit, [6:2]) and funct3 branch constants.
  - State encodings ST_FETCH..ST_HALT.
- One sub-module: branch_resolve.
  - Combinational: funct3, breq, brlt -> taken.
  - Reused by the later pipelined core.

Test Plan:
1. Reset, then ADDI (32'h00100093) with ack in the same cycle as req -> O_state 0,1,2,4,0; O_rf_we high for exactly 1 cycle; O_pc 0->4.
2. LW (32'h0000A103) with dmem ack 3 cycles after req -> O_dmem_req high for 4 cycles, O_dmem_we=0, O_rf_we in WB, 8 cycles total, O_pc=4.
3. BEQ with breq=1, alu_result=32'h40 -> O_pc=32'h40, O_rf_we=0; repeat with breq=0 -> O_pc=4. BGEU with brlt=1 -> not taken, O_brun=1.
4. Fetch returns 32'h00000000, or opcode 7'b1111111 -> O_fault=1 after DECODE; state 7; O_imem_req stays 0 for 20 cycles.
5. Timeout: TIMEOUT=16, imem never acks -> O_fault rises exactly 16 cycles after req; ack arriving on cycle 16 -> no fault, DECODE.
6. I_rstn pulsed low during MEM of an SW -> O_dmem_req falls asynchronously, O_pc=RESET_PC, O_fault=0; fetch restarts on the first edge after release.
